// File: rtl/dspm_way_seq_pkg.sv
// Shared types and constants for the data-cache way repartitioning sequencer.
// Provides:
//   dspm_seq_state_e  - sequencer states (IDLE, FLUSH, SWEEP, COMMIT)
//   SPM_ERR_PATTERN   - word the SPM controller returns for ways that are not active
//   line_offset_width - byte-offset width of one cache line, $clog2(LINE_WIDTH/8)
package dspm_way_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        SWEEP  = 2'd2,
        COMMIT = 2'd3
    } dspm_seq_state_e;

    localparam logic [63:0] SPM_ERR_PATTERN = 64'hBADC_AB1E_BADC_AB1E;

    function automatic int unsigned line_offset_width(input int unsigned line_width);
        return $clog2(line_width / 8);
    endfunction

endpackage

// File: rtl/dspm_way_seq_counter.sv
// Natural up-counter used as the sweep line index.
// Ports:
//   clk_i   - clock
//   rst_i   - asynchronous active-high reset (count -> 0)
//   clear_i - synchronous clear, has priority over en_i
//   en_i    - increment by one, wraps naturally at 2**WIDTH
//   q_o     - current count
module dspm_way_seq_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (en_i) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign q_o = r_count;

endmodule

// File: rtl/dspm_way_seq.sv
// Sequences moving data-cache ways between cache mode and scratchpad (SPM) mode.
// A new SPM way mask is accepted from the CSR file; ways entering SPM mode first
// trigger a cache write-back/invalidate, then every line of each changed way is
// zeroed through the SRAM mux before the new mask is published.
// Ports:
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   cfg_ways_i/valid/ready - requested SPM way mask handshake
//   flush_req_o/ack_i     - write-back request to the cache controller, pulse ack
//   busy_o                - sequencer owns the SRAM mux
//   gnt_i                 - SRAM mux accepted the current sweep beat
//   req_o/addr_o/wdata_o/we_o/be_o - sweep write port towards the data-cache SRAMs
//   active_ways_o         - ways usable by the SPM controller
//   cache_ways_o          - ways usable by the cache
module dspm_way_seq
    import dspm_way_seq_pkg::*;
#(
    parameter int unsigned NR_WAYS      = 4,
    parameter int unsigned NR_SETS      = 256,
    parameter int unsigned LINE_WIDTH   = 128,
    parameter int unsigned MEMORY_WIDTH = 172,
    parameter int unsigned IDX_WIDTH    = 12
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NR_WAYS-1:0]            cfg_ways_i,
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    output logic                          flush_req_o,
    input  logic                          flush_ack_i,
    output logic                          busy_o,
    input  logic                          gnt_i,
    output logic [NR_WAYS-1:0]            req_o,
    output logic [IDX_WIDTH-1:0]          addr_o,
    output logic [MEMORY_WIDTH-1:0]       wdata_o,
    output logic                          we_o,
    output logic [(MEMORY_WIDTH+7)/8-1:0] be_o,
    output logic [NR_WAYS-1:0]            active_ways_o,
    output logic [NR_WAYS-1:0]            cache_ways_o
);

    localparam int unsigned IDX_BITS = (NR_SETS > 1) ? $clog2(NR_SETS) : 1;
    localparam int unsigned OFFS     = line_offset_width(LINE_WIDTH);

    dspm_seq_state_e    r_state;
    dspm_seq_state_e    w_state_next;
    logic [NR_WAYS-1:0] r_active;
    logic [NR_WAYS-1:0] r_target;
    logic [NR_WAYS-1:0] r_changed;
    logic [IDX_BITS-1:0] w_idx;
    logic [IDX_WIDTH-1:0] w_idx_ext;
    logic                w_cfg_hs;
    logic                w_beat;
    logic                w_last_beat;
    logic                w_in_seq;

    assign w_cfg_hs    = cfg_valid_i && (r_state == IDLE);
    assign w_beat      = (r_state == SWEEP) && gnt_i;
    assign w_last_beat = w_beat && (w_idx == IDX_BITS'(NR_SETS - 1));
    assign w_in_seq    = (r_state != IDLE);

    // Clearing on the last beat also covers non-power-of-two set counts.
    dspm_way_seq_counter #(
        .WIDTH (IDX_BITS)
    ) u_idx_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (w_last_beat || (r_state == COMMIT)),
        .en_i    (w_beat),
        .q_o     (w_idx)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_active  <= '0;
            r_target  <= '0;
            r_changed <= '0;
        end else begin
            if (w_cfg_hs) begin
                r_target  <= cfg_ways_i;
                r_changed <= cfg_ways_i ^ r_active;
            end
            if (r_state == COMMIT) begin
                r_active <= r_target;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (cfg_valid_i && ((cfg_ways_i ^ r_active) != '0)) begin
                    // Only ways entering SPM mode may hold dirty cache lines.
                    if ((cfg_ways_i & ~r_active) != '0) begin
                        w_state_next = FLUSH;
                    end else begin
                        w_state_next = SWEEP;
                    end
                end
            end
            FLUSH: begin
                if (flush_ack_i) begin
                    w_state_next = SWEEP;
                end
            end
            SWEEP: begin
                if (w_last_beat) begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_idx_ext = IDX_WIDTH'(w_idx);

    always_comb begin
        req_o   = '0;
        addr_o  = '0;
        wdata_o = '0;
        we_o    = 1'b0;
        be_o    = '0;
        if (r_state == SWEEP) begin
            req_o  = r_changed;
            addr_o = w_idx_ext << OFFS;
            we_o   = 1'b1;
            be_o   = '1;
        end
    end

    assign cfg_ready_o = (r_state == IDLE);
    assign flush_req_o = (r_state == FLUSH);
    assign busy_o      = w_in_seq;

    // Ways in transition belong to neither side until COMMIT has finished.
    assign active_ways_o = w_in_seq ? (r_active & ~r_changed) : r_active;
    assign cache_ways_o  = w_in_seq ? (~r_active & ~r_changed) : ~r_active;

endmodule
